// File: rtl/avalon_arb_pkg.sv
// Shared types and helpers for the Avalon-MM host arbiter.
//   arb_state_t : arbiter FSM states (IDLE, OWNED)
//   host_idx_t  : host index type for the default host count
//   BE_W        : byteenable width for the default data width
//   idx_w/be_w  : width helpers for parameterized instances
package avalon_arb_pkg;

    typedef enum logic {IDLE, OWNED} arb_state_t;

    // Index width, never narrower than one bit (N_HOSTS == 1 still needs a register).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int be_w(input int dw);
        return dw / 8;
    endfunction

    localparam int N_HOSTS_DFLT = 2;
    localparam int DATA_W_DFLT  = 32;
    localparam int BE_W         = DATA_W_DFLT / 8;

    typedef logic [idx_w(N_HOSTS_DFLT)-1:0] host_idx_t;

endpackage

// File: rtl/avalon_arbiter_if.sv
// Bundle of host-side and agent-side Avalon-MM signals around the arbiter.
//   slave  : arbiter view (takes host commands + agent responses, drives the rest)
//   master : host/agent model view (the mirror image)
interface avalon_arbiter_if #(
    parameter int N_HOSTS = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    import avalon_arb_pkg::*;

    localparam int BW = be_w(DATA_W);

    logic [N_HOSTS-1:0][ADDR_W-1:0] h_address;
    logic [N_HOSTS-1:0]             h_read;
    logic [N_HOSTS-1:0]             h_write;
    logic [N_HOSTS-1:0][DATA_W-1:0] h_writedata;
    logic [N_HOSTS-1:0][BW-1:0]     h_byteenable;
    logic [N_HOSTS-1:0]             h_lock;
    logic [N_HOSTS-1:0]             h_waitrequest;
    logic [DATA_W-1:0]              h_readdata;

    logic [ADDR_W-1:0]              a_address;
    logic                           a_read;
    logic                           a_write;
    logic [DATA_W-1:0]              a_writedata;
    logic [BW-1:0]                  a_byteenable;
    logic                           a_waitrequest;
    logic [DATA_W-1:0]              a_readdata;

    logic [N_HOSTS-1:0]             grant;

    modport slave (
        input  h_address, h_read, h_write, h_writedata, h_byteenable, h_lock,
        input  a_waitrequest, a_readdata,
        output h_waitrequest, h_readdata,
        output a_address, a_read, a_write, a_writedata, a_byteenable,
        output grant
    );

    modport master (
        output h_address, h_read, h_write, h_writedata, h_byteenable, h_lock,
        output a_waitrequest, a_readdata,
        input  h_waitrequest, h_readdata,
        input  a_address, a_read, a_write, a_writedata, a_byteenable,
        input  grant
    );

endinterface

// File: rtl/arb_rr_picker.sv
// Combinational winner picker, round-robin or fixed priority.
//   req        : request mask
//   excl_idx   : index to drop from req when excl_vld (stale, just-completed owner)
//   ptr        : round-robin start index (ignored when fixed_prio)
//   fixed_prio : 1 = lowest index wins
//   win_oh     : one-hot winner, win_vld : any winner
module arb_rr_picker #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] excl_idx,
    input  logic          excl_vld,
    input  logic [IW-1:0] ptr,
    input  logic          fixed_prio,
    output logic [N-1:0]  win_oh,
    output logic          win_vld
);
    logic [N-1:0]  mask;
    logic [IW-1:0] idx;

    always_comb begin
        mask = req;
        if (excl_vld) mask[excl_idx] = 1'b0;
        win_oh  = '0;
        win_vld = 1'b0;
        idx     = '0;
        // Scan N candidates starting at ptr (or 0); the first hit wins.
        for (int k = 0; k < N; k++) begin
            idx = fixed_prio ? IW'(k) : IW'((int'(ptr) + k) % N);
            if (!win_vld && mask[idx]) begin
                win_oh[idx] = 1'b1;
                win_vld     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/avalon_arbiter.sv
// Registered-grant arbiter sharing one Avalon-MM agent between N_HOSTS hosts.
//   clk, rst : clock, synchronous active-low reset
//   bus      : host commands/responses, agent command/response, one-hot grant
// A grant is registered one cycle after a request; the owner's command is then
// muxed straight to the agent. On each completion the grant is either kept
// (h_lock, bounded by LOCK_MAX cycles) or handed back-to-back to the next
// requester, skipping the owner's just-completed request.
module avalon_arbiter #(
    parameter int N_HOSTS    = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0,
    parameter int LOCK_MAX   = 16
) (
    input  logic             clk,
    input  logic             rst,
    avalon_arbiter_if.slave  bus
);
    import avalon_arb_pkg::*;

    localparam int IW    = idx_w(N_HOSTS);
    localparam int CNT_W = idx_w(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'((LOCK_MAX > 0) ? LOCK_MAX - 1 : 0);

    arb_state_t         state;
    logic [IW-1:0]      g;
    logic [N_HOSTS-1:0] grant_q;
    logic [IW-1:0]      rr_ptr;
    logic [CNT_W-1:0]   lock_cnt;

    logic               owned, own_req, a_rd, a_wr, done, lock_ok;
    logic [IW-1:0]      g_nxt, pick_ptr, win_idx;
    logic [N_HOSTS-1:0] req, win_oh, hw;
    logic               win_vld;

    assign req     = bus.h_read | bus.h_write;
    assign owned   = (state == OWNED);
    assign own_req = req[g];
    assign a_rd    = owned & bus.h_read[g];
    assign a_wr    = owned & bus.h_write[g];
    assign done    = (a_rd | a_wr) & ~bus.a_waitrequest;
    assign lock_ok = (LOCK_MAX != 0) && bus.h_lock[g] && (lock_cnt < LOCK_LAST);
    assign g_nxt   = (g == IW'(N_HOSTS - 1)) ? '0 : g + 1'b1;
    // While owned, the re-arbitration uses the pointer the completion is about to set.
    assign pick_ptr = owned ? g_nxt : rr_ptr;

    arb_rr_picker #(.N(N_HOSTS), .IW(IW)) u_pick (
        .req        (req),
        .excl_idx   (g),
        .excl_vld   (owned),
        .ptr        (pick_ptr),
        .fixed_prio (FIXED_PRIO != 0),
        .win_oh     (win_oh),
        .win_vld    (win_vld)
    );

    always_comb begin
        win_idx = '0;
        for (int k = 0; k < N_HOSTS; k++)
            if (win_oh[k]) win_idx = IW'(k);
    end

    always_comb begin
        hw = '1;
        if (owned) hw[g] = bus.a_waitrequest;
    end

    assign bus.a_address     = owned ? bus.h_address[g]    : '0;
    assign bus.a_writedata   = owned ? bus.h_writedata[g]  : '0;
    assign bus.a_byteenable  = owned ? bus.h_byteenable[g] : '0;
    assign bus.a_read        = a_rd;
    assign bus.a_write       = a_wr;
    assign bus.h_waitrequest = hw;
    assign bus.h_readdata    = bus.a_readdata;
    assign bus.grant         = grant_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            g        <= '0;
            grant_q  <= '0;
            rr_ptr   <= '0;
            lock_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state    <= OWNED;
                        g        <= win_idx;
                        grant_q  <= win_oh;
                        lock_cnt <= '0;
                    end
                end
                OWNED: begin
                    if (done) rr_ptr <= g_nxt;
                    // Release on an unlocked/expired completion, or when the owner
                    // goes idle without a live lock.
                    if ((done || !own_req) && !lock_ok) begin
                        lock_cnt <= '0;
                        if (done && win_vld) begin
                            g       <= win_idx;
                            grant_q <= win_oh;
                        end else begin
                            state   <= IDLE;
                            grant_q <= '0;
                        end
                    end else if (lock_cnt < LOCK_LAST) begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
